// File: rtl/md_unit.sv
// md_unit: multiply/divide unit for the EX stage of the five-stage pipeline.
// Runs MULT/MULTU/DIV/DIVU over a fixed number of cycles, owns HI/LO, writes
// HI/LO directly on MTHI/MTLO and raises md_stall for dependent decode ops.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-low reset
//   start     in   EX-stage instruction is an MD op (qualifies md_op)
//   md_op     in   [2:0] 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, else none
//   a         in   [31:0] rs operand
//   b         in   [31:0] rt operand
//   id_is_md  in   decode-stage instruction touches HI/LO
//   busy      out  multi-cycle operation in progress
//   md_stall  out  combinational stall request to PC and IF/ID
//   hi        out  [31:0] committed HI
//   lo        out  [31:0] committed LO
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        id_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 4;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tmp_hi_q, tmp_hi_d;
  logic [DW-1:0] tmp_lo_q, tmp_lo_d;
  logic          commit_q, commit_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;

  // Arithmetic datapath, evaluated from the operands present at the issue edge
  logic [2*DW-1:0] mul_s, mul_u;
  logic [DW-1:0]   div_den;
  logic [DW-1:0]   a_mag, b_mag;
  logic [DW-1:0]   quo_mag, rem_mag;
  logic [DW-1:0]   quo_s, rem_s;
  logic [DW-1:0]   quo_u, rem_u;
  logic            is_md_long;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product
  assign mul_s = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
  assign mul_u = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};

  // Divisor forced nonzero so the divider never sees x/0; result is discarded
  assign div_den = (b == '0) ? DW'(1) : b;

  // Signed divide via magnitudes: quotient sign is a^b, remainder follows a.
  // 0x80000000 magnitude stays 2^31 unsigned, so MIN/-1 wraps to MIN.
  assign a_mag   = a[DW-1] ? DW'(-a) : a;
  assign b_mag   = div_den[DW-1] ? DW'(-div_den) : div_den;
  assign quo_mag = a_mag / b_mag;
  assign rem_mag = a_mag % b_mag;
  assign quo_s   = (a[DW-1] ^ div_den[DW-1]) ? DW'(-quo_mag) : quo_mag;
  assign rem_s   = a[DW-1] ? DW'(-rem_mag) : rem_mag;

  assign quo_u = a / div_den;
  assign rem_u = a % div_den;

  assign is_md_long = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    commit_d = commit_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT: begin
              {tmp_hi_d, tmp_lo_d} = mul_s;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = S_BUSY;
            end
            OP_MULTU: begin
              {tmp_hi_d, tmp_lo_d} = mul_u;
              cnt_d    = CW'(MULT_CYCLES);
              commit_d = 1'b1;
              state_d  = S_BUSY;
            end
            OP_DIV: begin
              tmp_hi_d = rem_s;
              tmp_lo_d = quo_s;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = (b != '0);
              state_d  = S_BUSY;
            end
            OP_DIVU: begin
              tmp_hi_d = rem_u;
              tmp_lo_d = quo_u;
              cnt_d    = CW'(DIV_CYCLES);
              commit_d = (b != '0);
              state_d  = S_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // New starts are ignored here; decode stall keeps them from arriving
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (commit_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      commit_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      commit_q <= commit_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy     = (state_q == S_BUSY);
  assign hi       = hi_q;
  assign lo       = lo_q;
  // Covers the issue cycle as well as the whole busy window
  assign md_stall = id_is_md & (busy | (start & is_md_long));

endmodule
